// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor: consumes one operand pair LSB-first, one bit per clock,
// and presents the sum or difference with carry and signed overflow after WIDTH clocks.
module serial_adder_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             k,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_count;

   logic             w_sum;
   logic             w_carry;
   logic             w_last;

   assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
   assign w_last  = (r_count == CW'(WIDTH - 1));

   // Subtraction is a + ~b + 1: b is inverted on entry and k seeds the carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b ^ {WIDTH{k}};
                  r_carry <= k;
                  r_count <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_res   <= {w_sum, r_res[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_carry;
               r_count <= r_count + CW'(1);
               // On the MSB, r_carry is the carry into it and w_carry the carry out.
               if (w_last) begin
                  s       <= {w_sum, r_res[WIDTH-1:1]};
                  cout    <= w_carry;
                  ovf     <= r_carry ^ w_carry;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Scoreboard bench for serial_adder_subtractor: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_serial_adder_subtractor;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             k;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      logic [31:0]      doneCycle;
   } expected_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             k;
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
   } vector_t;

   expected_t   sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] cycle = 0;

   serial_adder_subtractor #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .k    (k),
      .busy (busy),
      .done (done),
      .s    (s),
      .cout (cout),
      .ovf  (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Drives one request for a single accepting edge and records what should come back.
   task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vk,
                                input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      expected_t e;
      start = 1'b1;
      a     = va;
      b     = vb;
      k     = vk;
      @(posedge clk);
      #1;
      e.s         = es;
      e.cout      = ec;
      e.ovf       = eo;
      e.doneCycle = cycle + WIDTH;
      sb.push_back(e);
      start = 1'b0;
   endtask

   task automatic waitDone();
      bit seen = 0;
      for (int i = 0; i < 4 * WIDTH; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", 4 * WIDTH);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cycle);
         end else begin
            expected_t e;
            e = sb.pop_front();
            checkOutput("s", 32'(s), 32'(e.s));
            checkOutput("cout", 32'(cout), 32'(e.cout));
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            checkOutput("done_latency", cycle, e.doneCycle);
            checkOutput("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vector_t vectors[6];
      vectors[0] = '{a: 4'd1, b: 4'd2, k: 1'b0, s: 4'd3,  cout: 1'b0, ovf: 1'b0};
      vectors[1] = '{a: 4'd6, b: 4'd1, k: 1'b1, s: 4'd5,  cout: 1'b1, ovf: 1'b0};
      vectors[2] = '{a: 4'd3, b: 4'd5, k: 1'b1, s: 4'd14, cout: 1'b0, ovf: 1'b0};
      vectors[3] = '{a: 4'd15, b: 4'd1, k: 1'b0, s: 4'd0, cout: 1'b1, ovf: 1'b0};
      vectors[4] = '{a: 4'd7, b: 4'd1, k: 1'b0, s: 4'd8,  cout: 1'b0, ovf: 1'b1};
      vectors[5] = '{a: 4'd8, b: 4'd1, k: 1'b1, s: 4'd7,  cout: 1'b1, ovf: 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      k     = 1'b0;
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_s", 32'(s), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors, one at a time.
      foreach (vectors[i]) begin
         @(negedge clk);
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].k, vectors[i].s, vectors[i].cout, vectors[i].ovf);
         checkOutput("busy_after_start", 32'(busy), 32'd1);
         waitDone();
      end

      // Back-to-back: second request issued in the done cycle of the first.
      @(negedge clk);
      applyStimulus(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
      waitDone();
      applyStimulus(4'd6, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         checkOutput("b2b_hold_s", 32'(s), 32'd0);
         checkOutput("b2b_hold_cout", 32'(cout), 32'd1);
         checkOutput("b2b_no_early_done", 32'(done), 32'd0);
      end
      waitDone();

      // Requests and operand changes while busy must be ignored.
      @(negedge clk);
      applyStimulus(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a     = 4'd15;
      b     = 4'd15;
      k     = 1'b1;
      @(negedge clk);
      a     = 4'd0;
      b     = 4'd7;
      k     = 1'b0;
      @(negedge clk);
      start = 1'b0;
      waitDone();
      @(negedge clk);
      checkOutput("idle_after_done", 32'(busy), 32'd0);

      // Reset in the middle of an operation.
      @(negedge clk);
      applyStimulus(4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_s", 32'(s), 32'd0);
      checkOutput("abort_cout", 32'(cout), 32'd0);
      checkOutput("abort_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(negedge clk);
         checkOutput("abort_no_done", 32'(done), 32'd0);
         checkOutput("abort_idle", 32'(busy), 32'd0);
      end

      // Recovery after reset.
      applyStimulus(4'd6, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0);
      waitDone();
      @(negedge clk);
      @(negedge clk);
      checkOutput("hold_in_idle_s", 32'(s), 32'd5);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
